// File: rtl/fns_coder_pkg.sv
// Shared constants and the odd/even pair rule for the 9-TSV fault-tolerant
// crosstalk-avoidance codec.
package fns_coder_pkg;

  localparam int N_TSV      = 9;
  localparam int DATA_W     = 3;
  localparam int CNT_W      = 7;
  localparam int MAX_FAULTS = 5;

  // Pair of adjacent TSVs (hi = i+1, lo = i). The only forbidden combination
  // is an enabled odd TSV at 1 next to an enabled even TSV at 0.
  function automatic logic pair_ok(input logic hi_odd, input logic en_hi,
                                   input logic en_lo, input logic b_hi,
                                   input logic b_lo);
    logic odd_b;
    logic even_b;
    odd_b  = hi_odd ? b_hi : b_lo;
    even_b = hi_odd ? b_lo : b_hi;
    if (!(en_hi && en_lo)) return 1'b1;
    return !(odd_b && !even_b);
  endfunction

endpackage

// File: rtl/fns_adders_4_5.sv
// Count table for the enumerative code: L[i][s] valid completions of bits
// i-1..0 given bit i = s, plus the total number of codewords T.
module fns_adders_4_5
  import fns_coder_pkg::*;
(
  input  logic [N_TSV-1:0]       en_i,
  output logic [N_TSV*CNT_W-1:0] l0_o,
  output logic [CNT_W-1:0]       total_o
);

  logic [CNT_W-1:0] l_tab [N_TSV][2];

  always_comb begin
    for (int i = 0; i < N_TSV; i++) begin
      l_tab[i][0] = '0;
      l_tab[i][1] = '0;
    end
    l_tab[0][0] = CNT_W'(1);
    l_tab[0][1] = CNT_W'(1);
    // A disabled lower TSV can only hold 0, so t = 1 is skipped for it.
    for (int i = 1; i < N_TSV; i++) begin
      for (int s = 0; s < 2; s++) begin
        for (int t = 0; t < 2; t++) begin
          if ((t == 0 || en_i[i-1]) &&
              pair_ok(i[0], en_i[i], en_i[i-1], s[0], t[0])) begin
            l_tab[i][s] = l_tab[i][s] + l_tab[i-1][t];
          end
        end
      end
    end
    for (int i = 0; i < N_TSV; i++) begin
      l0_o[i*CNT_W +: CNT_W] = l_tab[i][0];
    end
    total_o = l_tab[N_TSV-1][0] + (en_i[N_TSV-1] ? l_tab[N_TSV-1][1] : '0);
  end

endmodule

// File: rtl/fns_coder_4_5.sv
// 3-bit word <-> 9-TSV codec skipping faulty TSVs. Encoder output registered;
// decoder combinational unless FNS_CODER_DEC_REG_EN is defined.
module fns_coder_4_5
  import fns_coder_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] datain,
  input  logic [N_TSV-1:0]  f_flag,
  output logic [N_TSV-1:0]  en_flag,
  output logic [N_TSV-1:0]  tsv,
  output logic              code_ovf,
  input  logic [N_TSV-1:0]  tsv_rx,
  output logic [DATA_W-1:0] dataout
);

  logic [N_TSV*CNT_W-1:0] l0;
  logic [CNT_W-1:0]       total;
  logic [N_TSV:0]         en_ext;
  logic [N_TSV:0]         rx_ext;
  logic [N_TSV-1:0]       tsv_d, tsv_q;
  logic                   ovf_d, ovf_q;
  logic [DATA_W-1:0]      dec_d;

  assign en_flag = ~f_flag;
  // Virtual disabled TSV above bit 8 leaves the top bit unconstrained.
  assign en_ext  = {1'b0, en_flag};
  assign rx_ext  = {1'b0, tsv_rx};

  fns_adders_4_5 u_adders (
    .en_i    (en_flag),
    .l0_o    (l0),
    .total_o (total)
  );

  always_comb begin
    logic [CNT_W-1:0] v;
    logic [CNT_W-1:0] c0;
    logic [N_TSV:0]   code;
    v    = CNT_W'(datain);
    code = '0;
    for (int i = N_TSV - 1; i >= 0; i--) begin
      c0 = pair_ok(!i[0], en_ext[i+1], en_ext[i], code[i+1], 1'b0) ?
           l0[i*CNT_W +: CNT_W] : '0;
      if (en_ext[i] && pair_ok(!i[0], en_ext[i+1], en_ext[i], code[i+1], 1'b1) &&
          v >= c0) begin
        code[i] = 1'b1;
        v       = v - c0;
      end
    end
    ovf_d = (CNT_W'(datain) >= total);
    tsv_d = ovf_d ? '0 : code[N_TSV-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tsv_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      tsv_q <= tsv_d;
      ovf_q <= ovf_d;
    end
  end

  assign tsv      = tsv_q;
  assign code_ovf = ovf_q;

  // Rank of the received word; only its low bits are needed, so the sum wraps.
  always_comb begin
    dec_d = '0;
    for (int i = N_TSV - 1; i >= 0; i--) begin
      if (rx_ext[i] && pair_ok(!i[0], en_ext[i+1], en_ext[i], rx_ext[i+1], 1'b0)) begin
        dec_d = dec_d + l0[i*CNT_W +: DATA_W];
      end
    end
  end

`ifdef FNS_CODER_DEC_REG_EN
  logic [DATA_W-1:0] dec_q;

  always_ff @(posedge clock) begin
    if (reset) dec_q <= '0;
    else       dec_q <= dec_d;
  end

  assign dataout = dec_q;
`else
  assign dataout = dec_d;
`endif

endmodule

// File: tb/tb_fns_coder_4_5.sv
// Bench for fns_coder_4_5: reference code table built by enumerating all
// 512 bundle words and keeping the valid ones in ascending order.
module tb_fns_coder_4_5;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] datain;
  logic [8:0] f_flag;
  logic [8:0] en_flag;
  logic [8:0] tsv;
  logic       code_ovf;
  logic [8:0] tsv_rx;
  logic [2:0] dataout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] code_tab[$];
  logic [8:0] exp_q[$];

  logic [2:0] dir_d[6] = '{3'd5, 3'd0, 3'd2, 3'd4, 3'd7, 3'd2};
  logic [8:0] dir_f[6] = '{9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'b000000001};
  logic [8:0] dir_e[6] = '{9'b000010000, 9'b000000000, 9'b000000100,
                           9'b000000111, 9'b000010100, 9'b000000110};

  always #5 clock = ~clock;

  fns_coder_4_5 dut (
    .clock    (clock),
    .reset    (reset),
    .datain   (datain),
    .f_flag   (f_flag),
    .en_flag  (en_flag),
    .tsv      (tsv),
    .code_ovf (code_ovf),
    .tsv_rx   (tsv_rx),
    .dataout  (dataout)
  );

  function automatic bit word_ok(input logic [8:0] w, input logic [8:0] en);
    if ((w & ~en) != 9'd0) return 1'b0;
    for (int i = 1; i < 9; i += 2) begin
      if (en[i] && w[i]) begin
        if (en[i-1] && !w[i-1]) return 1'b0;
        if (en[i+1] && !w[i+1]) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  task automatic build_table(input logic [8:0] f);
    code_tab.delete();
    for (int w = 0; w < 512; w++) begin
      if (word_ok(9'(w), ~f)) code_tab.push_back(9'(w));
    end
  endtask

  task automatic settle_decode();
`ifdef FNS_CODER_DEC_REG_EN
    @(posedge clock); #1;
`else
    #1;
`endif
  endtask

  task automatic drive_word(input logic [8:0] f, input logic [2:0] d);
    f_flag = f;
    datain = d;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    datain = 3'd5;
    f_flag = 9'd0;
    tsv_rx = 9'd0;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (tsv !== 9'd0) begin n_fail++; $display("FAIL reset_tsv: got %b expected %b", tsv, 9'd0); end
    n_checks++;
    if (code_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", code_ovf); end
    n_checks++;
    if (dataout !== 3'd0) begin n_fail++; $display("FAIL reset_dataout: got %0d expected 0", dataout); end
    n_checks++;
    if (en_flag !== ~f_flag) begin n_fail++; $display("FAIL reset_en_flag: got %b expected %b", en_flag, ~f_flag); end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    for (int k = 0; k < 6; k++) begin
      drive_word(dir_f[k], dir_d[k]);
      n_checks++;
      if (tsv !== dir_e[k]) begin n_fail++; $display("FAIL directed_tsv[%0d]: got %b expected %b", k, tsv, dir_e[k]); end
      n_checks++;
      if (code_ovf !== 1'b0) begin n_fail++; $display("FAIL directed_ovf[%0d]: got %b expected 0", k, code_ovf); end
      n_checks++;
      if (en_flag !== ~dir_f[k]) begin n_fail++; $display("FAIL directed_en[%0d]: got %b expected %b", k, en_flag, ~dir_f[k]); end
      tsv_rx = dir_e[k];
      settle_decode();
      n_checks++;
      if (dataout !== dir_d[k]) begin n_fail++; $display("FAIL directed_dec[%0d]: got %0d expected %0d", k, dataout, dir_d[k]); end
    end
  endtask

  task automatic test_loopback(input int rounds);
    logic [8:0] f;
    logic [8:0] e;
    logic [2:0] d;
    int b;
    for (int r = 0; r < rounds; r++) begin
      f = 9'd0;
      for (int step = 0; step <= 5; step++) begin
        if (step > 0) begin
          do b = $urandom_range(0, 8); while (f[b]);
          f[b] = 1'b1;
        end
        build_table(f);
        for (int k = 0; k < 20; k++) begin
          d = 3'($urandom_range(0, 7));
          exp_q.push_back((int'(d) < code_tab.size()) ? code_tab[d] : 9'd0);
          drive_word(f, d);
          e = exp_q.pop_front();
          n_checks++;
          if (tsv !== e) begin n_fail++; $display("FAIL loop_tsv f=%b d=%0d: got %b expected %b", f, d, tsv, e); end
          n_checks++;
          if (code_ovf !== (int'(d) >= code_tab.size())) begin n_fail++; $display("FAIL loop_ovf f=%b d=%0d: got %b", f, d, code_ovf); end
          n_checks++;
          if ((tsv & f) !== 9'd0) begin n_fail++; $display("FAIL loop_faulty_bit f=%b: got %b expected faulty bits 0", f, tsv); end
          n_checks++;
          if (!word_ok(tsv, ~f)) begin n_fail++; $display("FAIL loop_forbidden_pair f=%b: got %b expected valid word", f, tsv); end
          tsv_rx = tsv;
          settle_decode();
          n_checks++;
          if (dataout !== d) begin n_fail++; $display("FAIL loop_dec f=%b rx=%b: got %0d expected %0d", f, tsv_rx, dataout, d); end
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [8:0] f;
    logic [8:0] e;
    f = 9'b111111000;
    build_table(f);
    for (int d = 0; d < 8; d++) begin
      drive_word(f, 3'(d));
      e = (d < code_tab.size()) ? code_tab[d] : 9'd0;
      n_checks++;
      if (tsv !== e) begin n_fail++; $display("FAIL ovf_tsv d=%0d: got %b expected %b", d, tsv, e); end
      n_checks++;
      if (code_ovf !== (d >= code_tab.size())) begin n_fail++; $display("FAIL ovf_flag d=%0d: got %b expected %b", d, code_ovf, d >= code_tab.size()); end
      if (d < code_tab.size()) begin
        tsv_rx = tsv;
        settle_decode();
        n_checks++;
        if (dataout !== 3'(d)) begin n_fail++; $display("FAIL ovf_dec d=%0d: got %0d expected %0d", d, dataout, d); end
      end
    end
  endtask

  task automatic test_decode_codewords();
    logic [8:0] f;
    int k;
    for (int n = 0; n < 60; n++) begin
      f = 9'd0;
      repeat ($urandom_range(0, 5)) f[$urandom_range(0, 8)] = 1'b1;
      build_table(f);
      k = $urandom_range(0, code_tab.size() - 1);
      f_flag = f;
      tsv_rx = code_tab[k];
      settle_decode();
      n_checks++;
      if (dataout !== 3'(k)) begin n_fail++; $display("FAIL rank_dec f=%b rx=%b: got %0d expected %0d", f, tsv_rx, dataout, 3'(k)); end
    end
  endtask

  task automatic test_reset_midstream();
    drive_word(9'b111111000, 3'd7);
    n_checks++;
    if (code_ovf !== 1'b1) begin n_fail++; $display("FAIL mid_pre_ovf: got %b expected 1", code_ovf); end
    f_flag = 9'd0;
    tsv_rx = 9'b000010100;
    reset  = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if (tsv !== 9'd0) begin n_fail++; $display("FAIL mid_reset_tsv: got %b expected 0", tsv); end
    n_checks++;
    if (code_ovf !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ovf: got %b expected 0", code_ovf); end
    n_checks++;
`ifdef FNS_CODER_DEC_REG_EN
    if (dataout !== 3'd0) begin n_fail++; $display("FAIL mid_reset_dec: got %0d expected 0", dataout); end
`else
    if (dataout !== 3'd7) begin n_fail++; $display("FAIL mid_reset_dec: got %0d expected 7", dataout); end
`endif
    reset = 1'b0;
    @(posedge clock); #1;
    n_checks++;
    if (tsv !== 9'b000010100) begin n_fail++; $display("FAIL mid_after_tsv: got %b expected 000010100", tsv); end
    n_checks++;
    if (dataout !== 3'd7) begin n_fail++; $display("FAIL mid_after_dec: got %0d expected 7", dataout); end
    tsv_rx = 9'b000000100;
    #1;
    n_checks++;
`ifdef FNS_CODER_DEC_REG_EN
    if (dataout !== 3'd7) begin n_fail++; $display("FAIL mid_lag_dec: got %0d expected 7", dataout); end
`else
    if (dataout !== 3'd2) begin n_fail++; $display("FAIL mid_lag_dec: got %0d expected 2", dataout); end
`endif
    @(posedge clock); #1;
    n_checks++;
    if (dataout !== 3'd2) begin n_fail++; $display("FAIL mid_settled_dec: got %0d expected 2", dataout); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_loopback(200);
    test_overflow();
    test_decode_codewords();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
